// File: rtl/sweep_gate_controller_pkg.sv
// ---------------------------------------------------------------------------
// freq_meter_pkg
//   Shared types and constants for the frequency meter measurement sequencer.
//   - state_t      : measurement FSM states (IDLE encodes as 0)
//   - SW_*         : divider select codes (SW_DEFAULT = 10 MHz default source)
//   - SWEEP_TABLE  : 12-entry auto-sweep sequence, entry 0 first
//   - sweep_code() : bounded lookup into SWEEP_TABLE
//   - max_u()      : constant helper for sizing timers
// ---------------------------------------------------------------------------
package freq_meter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_GATE   = 3'd4,
    ST_REPORT = 3'd5
  } state_t;

  localparam logic [7:0] SW_DEFAULT = 8'h00;
  localparam logic [7:0] SW_S0      = 8'h01;
  localparam logic [7:0] SW_S1      = 8'h02;
  localparam logic [7:0] SW_S2      = 8'h04;
  localparam logic [7:0] SW_S3      = 8'h08;
  localparam logic [7:0] SW_S4      = 8'h10;
  localparam logic [7:0] SW_S5      = 8'h20;
  localparam logic [7:0] SW_S6      = 8'h40;
  localparam logic [7:0] SW_S7      = 8'h80;
  localparam logic [7:0] SW_S8      = 8'h60;
  localparam logic [7:0] SW_S9      = 8'hA0;
  localparam logic [7:0] SW_S10     = 8'hC0;
  localparam logic [7:0] SW_S11     = 8'hE0;

  localparam int unsigned SWEEP_LEN = 12;

  // Packed so entry [0] is the rightmost element of the concatenation.
  localparam logic [11:0][7:0] SWEEP_TABLE = {
    SW_S11, SW_S10, SW_S9, SW_S8, SW_S7, SW_S6,
    SW_S5,  SW_S4,  SW_S3, SW_S2, SW_S1, SW_S0
  };

  // Indices past the table fall back to the divider default.
  function automatic logic [7:0] sweep_code(input logic [3:0] idx);
    if (idx < 4'(SWEEP_LEN)) sweep_code = SWEEP_TABLE[idx];
    else                     sweep_code = SW_DEFAULT;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sweep_gate_controller_if.sv
// ---------------------------------------------------------------------------
// sweep_gate_controller_if
//   Bundles the control/readout signals of the measurement sequencer.
//   master modport : the board/readout side (drives start/abort/mode/switches/ack)
//   slave modport  : the sequencer (drives divider select, counter control, status)
//
//   Readout handshake: meas_valid rises when a result is ready and stays high
//   until a cycle in which meas_ack is also high; that cycle completes the
//   transfer. meas_ack while meas_valid is low has no effect. abort in the same
//   cycle as meas_ack cancels the transfer's follow-on step (back to IDLE).
//
//   Signals:
//     start, abort, mode_auto, sw_manual[7:0], meas_ack   (master -> slave)
//     sel_code[7:0], cnt_clr, gate_en, meas_valid,
//     step_idx[3:0], busy, sweep_done, dbg_state          (slave -> master)
// ---------------------------------------------------------------------------
interface sweep_gate_controller_if;
  import freq_meter_pkg::*;

  logic       start;
  logic       abort;
  logic       mode_auto;
  logic [7:0] sw_manual;
  logic       meas_ack;

  logic [7:0] sel_code;
  logic       cnt_clr;
  logic       gate_en;
  logic       meas_valid;
  logic [3:0] step_idx;
  logic       busy;
  logic       sweep_done;
  state_t     dbg_state;

  modport master (
    output start, abort, mode_auto, sw_manual, meas_ack,
    input  sel_code, cnt_clr, gate_en, meas_valid, step_idx, busy, sweep_done, dbg_state
  );

  modport slave (
    input  start, abort, mode_auto, sw_manual, meas_ack,
    output sel_code, cnt_clr, gate_en, meas_valid, step_idx, busy, sweep_done, dbg_state
  );

endinterface

// File: rtl/sweep_gate_controller_cycle_timer.sv
// ---------------------------------------------------------------------------
// cycle_timer
//   Loadable down-counter with zero flag, shared by the settle and gate phases.
//   Ports:
//     clk_50M  in  clock
//     rst      in  asynchronous active-low reset (count -> 0)
//     load     in  load count with load_val (wins over en)
//     load_val in  W-bit value to load
//     en       in  decrement by one; holds at 0 (no wrap)
//     zero     out count == 0
// ---------------------------------------------------------------------------
module cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_50M,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sweep_gate_controller.sv
// ---------------------------------------------------------------------------
// sweep_gate_controller
//   Sequences one frequency measurement (or an auto sweep of them):
//   SELECT the divider code, SETTLE, CLEAR the edge counter, open the GATE,
//   then REPORT via meas_valid/meas_ack.
//   Ports:
//     clk_50M  in  50 MHz system clock
//     rst      in  asynchronous active-low reset
//     ctl      sweep_gate_controller_if.slave (see interface header)
//   Parameters:
//     SETTLE_CYCLES  settle time after a select-code change (>=1)
//     GATE_CYCLES    gate window length (>=1)
//     NUM_STEPS      sweep-table entries used in auto mode (1..12)
//   Build option:
//     CONTINUOUS_SWEEP_EN  when defined, an auto sweep restarts from entry 0
//                          after the last step instead of returning to IDLE.
// ---------------------------------------------------------------------------
module sweep_gate_controller
  import freq_meter_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned GATE_CYCLES   = 50_000_000,
  parameter int unsigned NUM_STEPS     = 12
) (
  input logic                      clk_50M,
  input logic                      rst,
  sweep_gate_controller_if.slave   ctl
);

  // Sized for the longer of the two phases so a large SETTLE_CYCLES still fits.
  localparam int unsigned TW = $clog2(max_u(GATE_CYCLES, SETTLE_CYCLES) + 1);
  // Phases run while the timer counts N-1 .. 0, i.e. exactly N cycles.
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LOAD   = TW'(GATE_CYCLES - 1);
  localparam logic [3:0]    LAST_STEP   = 4'(NUM_STEPS - 1);

  state_t        state, state_nxt;
  logic          mode_reg;
  logic [3:0]    step_q;
  logic [7:0]    sel_q;
  logic          done_q;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_en;
  logic          tmr_zero;

  logic          cnt_clr_c, gate_en_c, meas_valid_c, busy_c;
  logic          last_step;

  assign last_step = (step_q == LAST_STEP);

  cycle_timer #(.W(TW)) u_timer (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // State register
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; abort overrides everything, including a same-cycle ack.
  always_comb begin
    state_nxt = state;
    if (ctl.abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (ctl.start) state_nxt = ST_SELECT;
        ST_SELECT: state_nxt = ST_SETTLE;
        ST_SETTLE: if (tmr_zero) state_nxt = ST_CLEAR;
        ST_CLEAR:  state_nxt = ST_GATE;
        ST_GATE:   if (tmr_zero) state_nxt = ST_REPORT;
        ST_REPORT: begin
          if (ctl.meas_ack) begin
            if (!mode_reg)       state_nxt = ST_IDLE;
            else if (!last_step) state_nxt = ST_SELECT;
            else begin
`ifdef CONTINUOUS_SWEEP_EN
              state_nxt = ST_SELECT;
`else
              state_nxt = ST_IDLE;
`endif
            end
          end
        end
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output / timer-control decode from the current state.
  always_comb begin
    cnt_clr_c    = 1'b0;
    gate_en_c    = 1'b0;
    meas_valid_c = 1'b0;
    busy_c       = 1'b1;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    tmr_en       = 1'b0;
    case (state)
      ST_IDLE:   busy_c = 1'b0;
      ST_SELECT: begin
        tmr_load = 1'b1;
        tmr_val  = SETTLE_LOAD;
      end
      ST_SETTLE: tmr_en = 1'b1;
      ST_CLEAR:  begin
        cnt_clr_c = 1'b1;
        tmr_load  = 1'b1;
        tmr_val   = GATE_LOAD;
      end
      ST_GATE:   begin
        gate_en_c = 1'b1;
        tmr_en    = 1'b1;
      end
      ST_REPORT: meas_valid_c = 1'b1;
      default:   busy_c = 1'b0;
    endcase
  end

  // Datapath registers: latched mode, sweep index, select code, done pulse.
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      mode_reg <= 1'b0;
      step_q   <= '0;
      sel_q    <= SW_DEFAULT;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ctl.abort) begin
        // sel_q deliberately keeps its last value so the divider does not glitch.
        step_q <= '0;
      end else begin
        case (state)
          ST_IDLE:   if (ctl.start) mode_reg <= ctl.mode_auto;
          ST_SELECT: sel_q <= mode_reg ? sweep_code(step_q) : ctl.sw_manual;
          ST_REPORT: begin
            if (ctl.meas_ack && mode_reg) begin
              if (last_step) begin
                step_q <= '0;
                done_q <= 1'b1;
              end else begin
                step_q <= step_q + 4'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ctl.sel_code   = sel_q;
  assign ctl.cnt_clr    = cnt_clr_c;
  assign ctl.gate_en    = gate_en_c;
  assign ctl.meas_valid = meas_valid_c;
  assign ctl.step_idx   = step_q;
  assign ctl.busy       = busy_c;
  assign ctl.sweep_done = done_q;
  assign ctl.dbg_state  = state;

endmodule

// File: tb/tb_sweep_gate_controller.sv
// ---------------------------------------------------------------------------
// tb_sweep_gate_controller
//   Bench for sweep_gate_controller with SETTLE_CYCLES=4, GATE_CYCLES=10.
//   Default build: NUM_STEPS=12, single sweep.
//   With CONTINUOUS_SWEEP_EN defined: NUM_STEPS=3, repeating sweep.
//   Expected {step_idx, sel_code} per measurement goes into exp_q when a
//   measurement is launched; a negedge monitor times cnt_clr/gate_en/meas_valid
//   from the accepting edge and pops/compares on each meas_valid rise.
// ---------------------------------------------------------------------------
module tb_sweep_gate_controller;

  localparam int S = 4;
  localparam int G = 10;
`ifdef CONTINUOUS_SWEEP_EN
  localparam int N = 3;
`else
  localparam int N = 12;
`endif
  // Cycle offsets from the edge that accepts start/ack.
  localparam int CLR_OFF   = S + 2;
  localparam int GATE_OFF  = S + 3;
  localparam int VALID_OFF = S + G + 3;

  logic clk_50M = 1'b0;
  logic rst     = 1'b0;

  always #5 clk_50M = ~clk_50M;

  sweep_gate_controller_if ctl ();

  sweep_gate_controller #(
    .SETTLE_CYCLES (S),
    .GATE_CYCLES   (G),
    .NUM_STEPS     (N)
  ) dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .ctl     (ctl)
  );

  logic [7:0]  ref_table [12] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                  8'h40, 8'h80, 8'h60, 8'hA0, 8'hC0, 8'hE0};
  logic [11:0] exp_q [$];   // {step_idx, sel_code}

  int    checks    = 0;
  int    failures  = 0;
  int    exp_done  = 0;
  int    done_cnt  = 0;
  longint cyc      = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout, expected DUT event at t=%0t", name, $time);
  endtask

  // ---------------- clock/cycle bookkeeping + monitor ----------------
  always @(posedge clk_50M) cyc = cyc + 1;

  longint origin = 0;
  longint clr_off = -1, gate_first = -1;
  int     clr_cnt = 0, gate_cnt = 0;
  bit     prev_valid = 1'b0;

  always @(negedge clk_50M) begin
    longint     off;
    logic [11:0] e;
    if (!rst) begin
      prev_valid = 1'b0;
      clr_cnt    = 0;
      gate_cnt   = 0;
    end else begin
      off = cyc - origin;
      if (ctl.cnt_clr) begin
        clr_cnt++;
        clr_off = off;
      end
      if (ctl.gate_en) begin
        if (gate_cnt == 0) gate_first = off;
        gate_cnt++;
      end
      if (ctl.sweep_done) done_cnt++;
      if (ctl.meas_valid && !prev_valid) begin
        check("exp_q_nonempty_at_valid", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sel_code",     ctl.sel_code, e[7:0]);
          check("step_idx",     ctl.step_idx, e[11:8]);
          check("cnt_clr_len",  clr_cnt,      1);
          check("cnt_clr_cyc",  clr_off,      CLR_OFF);
          check("gate_first",   gate_first,   GATE_OFF);
          check("gate_len",     gate_cnt,     G);
          check("valid_cyc",    off,          VALID_OFF);
        end
      end
      prev_valid = ctl.meas_valid;
      // The next posedge accepts a start (IDLE) or an ack (REPORT): new origin.
      if (!ctl.abort && ((ctl.start && !ctl.busy) || (ctl.meas_ack && ctl.meas_valid))) begin
        origin   = cyc;
        clr_cnt  = 0;
        gate_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_50M);
    #2;
  endtask

  task automatic pulse_start(input bit auto_m, input logic [7:0] code);
    ctl.mode_auto = auto_m;
    ctl.sw_manual = code;
    ctl.start     = 1'b1;
    step();
    ctl.start     = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ctl.meas_valid) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    timeout_fail("wait_meas_valid");
  endtask

  task automatic wait_gate(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ctl.gate_en) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    timeout_fail("wait_gate_en");
  endtask

  task automatic do_ack(input int dly);
    repeat (dly) step();
    ctl.meas_ack = 1'b1;
    step();
    ctl.meas_ack = 1'b0;
  endtask

  task automatic run_manual(input logic [7:0] code, input bit noisy);
    bit ok;
    exp_q.push_back({4'd0, code});
    pulse_start(1'b0, code);
    step();
    check("sel_after_edge1", ctl.sel_code, code);
    if (noisy) begin
      // start, mode and switch changes while busy must all be ignored.
      ctl.start     = 1'b1;
      ctl.mode_auto = 1'b1;
      ctl.sw_manual = ~code;
      step();
      ctl.start     = 1'b0;
      wait_gate(ok);
      if (ok) begin
        ctl.meas_ack = 1'b1;
        step();
        ctl.meas_ack = 1'b0;
      end
    end
    wait_valid(ok);
    if (ok) begin
      do_ack($urandom_range(0, 4));
      check("manual_busy_after_ack",  ctl.busy,       0);
      check("manual_valid_after_ack", ctl.meas_valid, 0);
      check("manual_step_idx",        ctl.step_idx,   0);
    end
  endtask

  task automatic run_auto_single(input int fixed_dly);
    bit ok;
    for (int k = 0; k < N; k++) exp_q.push_back({4'(k), ref_table[k]});
    pulse_start(1'b1, 8'($urandom_range(0, 255)));
    for (int k = 0; k < N; k++) begin
      wait_valid(ok);
      if (!ok) return;
      do_ack((fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 4)));
    end
    exp_done++;
    check("auto_sweep_done_pulse", ctl.sweep_done, 1);
    check("auto_busy_end",         ctl.busy,       0);
    check("auto_step_idx_end",     ctl.step_idx,   0);
    step();
    check("auto_sweep_done_drop",  ctl.sweep_done, 0);
  endtask

  task automatic run_auto_continuous(input int total);
    bit ok;
    for (int k = 0; k < total; k++) exp_q.push_back({4'(k % N), ref_table[k % N]});
    pulse_start(1'b1, 8'($urandom_range(0, 255)));
    for (int k = 0; k < total; k++) begin
      wait_valid(ok);
      if (!ok) return;
      do_ack($urandom_range(0, 4));
      check("cont_busy", ctl.busy, 1);
      if ((k % N) == N - 1) begin
        exp_done++;
        check("cont_sweep_done", ctl.sweep_done, 1);
      end
    end
    ctl.abort = 1'b1;
    step();
    ctl.abort = 1'b0;
    check("cont_abort_busy", ctl.busy,     0);
    check("cont_abort_step", ctl.step_idx, 0);
  endtask

  task automatic run_abort_gate();
    bit ok;
    pulse_start(1'b0, 8'($urandom_range(0, 255)));
    wait_gate(ok);
    if (!ok) return;
    repeat (4) step();   // now in gate cycle 5
    ctl.abort = 1'b1;
    step();
    ctl.abort = 1'b0;
    check("abort_gate_en",    ctl.gate_en,    0);
    check("abort_busy",       ctl.busy,       0);
    check("abort_meas_valid", ctl.meas_valid, 0);
    check("abort_cnt_clr",    ctl.cnt_clr,    0);
    check("abort_step_idx",   ctl.step_idx,   0);
    repeat (G + 5) step();
    check("abort_no_valid",   ctl.meas_valid, 0);
  endtask

  // Auto sweep where the third report's ack coincides with abort.
  task automatic run_auto_ack_abort();
    bit ok;
    for (int k = 0; k < 3; k++) exp_q.push_back({4'(k), ref_table[k]});
    pulse_start(1'b1, 8'h00);
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      if (!ok) return;
      if (k < 2) begin
        do_ack($urandom_range(0, 3));
      end else begin
        ctl.meas_ack = 1'b1;
        ctl.abort    = 1'b1;
        step();
        ctl.meas_ack = 1'b0;
        ctl.abort    = 1'b0;
      end
    end
    check("ack_abort_busy",       ctl.busy,       0);
    check("ack_abort_step",       ctl.step_idx,   0);
    check("ack_abort_sweep_done", ctl.sweep_done, 0);
    check("ack_abort_sel_hold",   ctl.sel_code,   ref_table[2]);
  endtask

  task automatic run_reset_mid_gate();
    bit ok;
    pulse_start(1'b0, 8'h5A);
    wait_gate(ok);
    if (!ok) return;
    step();
    #1 rst = 1'b0;
    #1;
    check("rst_gate_en",    ctl.gate_en,    0);
    check("rst_busy",       ctl.busy,       0);
    check("rst_sel_code",   ctl.sel_code,   0);
    check("rst_cnt_clr",    ctl.cnt_clr,    0);
    check("rst_meas_valid", ctl.meas_valid, 0);
    step();
    step();
    rst = 1'b1;
    repeat (5) step();
    check("rst_no_resume",  ctl.busy,       0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    ctl.start     = 1'b0;
    ctl.abort     = 1'b0;
    ctl.mode_auto = 1'b0;
    ctl.sw_manual = 8'h00;
    ctl.meas_ack  = 1'b0;
    rst           = 1'b0;
    repeat (3) step();
    check("reset_sel_code",   ctl.sel_code,   0);
    check("reset_cnt_clr",    ctl.cnt_clr,    0);
    check("reset_gate_en",    ctl.gate_en,    0);
    check("reset_meas_valid", ctl.meas_valid, 0);
    check("reset_step_idx",   ctl.step_idx,   0);
    check("reset_busy",       ctl.busy,       0);
    check("reset_sweep_done", ctl.sweep_done, 0);
    rst = 1'b1;
    repeat (2) step();

    run_manual(8'h08, 1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 3)) step();
      run_manual(8'($urandom_range(0, 255)), 1'b0);
    end
    run_manual(8'($urandom_range(0, 255)), 1'b1);

`ifdef CONTINUOUS_SWEEP_EN
    run_auto_continuous(2 * N + 2);
`else
    run_auto_single(3);
    run_auto_single(-1);
`endif
    step();
    run_abort_gate();
    run_manual(8'($urandom_range(0, 255)), 1'b0);
    run_auto_ack_abort();
    step();
    run_reset_mid_gate();
    run_manual(8'($urandom_range(0, 255)), 1'b0);

    repeat (4) step();
    check("sweep_done_total", done_cnt,     exp_done);
    check("exp_q_drained",    exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected end of test by t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
